// File: rtl/ripple_pkg.sv
// rtl/ripple_pkg.sv - shared types and step classification for the ripple counter sampler
package ripple_pkg;

    typedef enum logic [1:0] {
        INIT,
        TRACK,
        SETTLE
    } state_t;

    localparam int STAB_W = 4;

    typedef struct packed {
        logic wrap_up;
        logic wrap_down;
        logic step_err;
    } step_class_t;

    // Classifies an accepted step prev -> next, both taken modulo 2^width.
    function automatic step_class_t classify_step(
        input logic [31:0] prev,
        input logic [31:0] next,
        input int unsigned width
    );
        logic [31:0] mask;
        logic [31:0] delta;
        step_class_t c;
        mask  = 32'hFFFF_FFFF >> (32 - width);
        delta = (next - prev) & mask;
        c     = '0;
        if (delta == 32'd1) begin
            c.wrap_up = ((prev & mask) == mask);
        end else if (delta == mask) begin
            c.wrap_down = ((prev & mask) == 32'd0);
        end else begin
            c.step_err = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// rtl/bit_sync.sv - multi-stage flip-flop synchroniser, cleared to zero on reset
module bit_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] sync_d [STAGES];

    always_comb begin
        sync_d[0] = d;
        for (int i = 1; i < STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/ripple_count_sampler.sv
// rtl/ripple_count_sampler.sv - debounced sampler of an asynchronous ripple counter
module ripple_count_sampler
    import ripple_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] cnt_async,
    input  logic             up_down_async,
    output logic [WIDTH-1:0] count,
    output logic             count_valid,
    output logic             wrap_up,
    output logic             wrap_down,
    output logic             step_err,
    output logic             dir
);

    localparam logic [STAB_W-1:0] STAB_DONE = STAB_W'(STABLE_CYCLES);

    logic [WIDTH-1:0] s;
    logic             dir_s;

    bit_sync #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_cnt_sync (
        .clk (clk),
        .rst (rst),
        .d   (cnt_async),
        .q   (s)
    );

    bit_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_dir_sync (
        .clk (clk),
        .rst (rst),
        .d   (up_down_async),
        .q   (dir_s)
    );

    assign dir = dir_s;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   cand_q, cand_d;
    logic [STAB_W-1:0]  stab_q, stab_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic               count_valid_q, count_valid_d;
    logic               wrap_up_q, wrap_up_d;
    logic               wrap_down_q, wrap_down_d;
    logic               step_err_q, step_err_d;
    // Tracks reset release through the synchroniser so INIT ignores not-yet-captured stages.
    logic [SYNC_STAGES-1:0] prime_q, prime_d;

    logic        load;
    logic        classify_en;
    step_class_t cls;

    always_comb begin
        state_d       = state_q;
        cand_d        = cand_q;
        stab_d        = stab_q;
        count_d       = count_q;
        count_valid_d = 1'b0;
        wrap_up_d     = 1'b0;
        wrap_down_d   = 1'b0;
        step_err_d    = 1'b0;
        prime_d       = {prime_q[SYNC_STAGES-2:0], 1'b1};
        load          = 1'b0;
        classify_en   = 1'b0;
        cls           = '0;

        case (state_q)
            INIT: begin
                if (prime_q[SYNC_STAGES-1]) begin
                    if (s == cand_q) begin
                        stab_d = stab_q + 1'b1;
                    end else begin
                        cand_d = s;
                        stab_d = STAB_W'(1);
                    end
                    if (stab_d == STAB_DONE) begin
                        load    = 1'b1;
                        state_d = TRACK;
                    end
                end
            end
            TRACK: begin
                if (s != count_q) begin
                    cand_d  = s;
                    stab_d  = STAB_W'(1);
                    state_d = SETTLE;
                    if (stab_d == STAB_DONE) begin
                        load        = 1'b1;
                        classify_en = 1'b1;
                        state_d     = TRACK;
                    end
                end
            end
            SETTLE: begin
                if (s == cand_q) begin
                    stab_d = stab_q + 1'b1;
                end else if (s == count_q) begin
                    state_d = TRACK;
                end else begin
                    cand_d = s;
                    stab_d = STAB_W'(1);
                end
                if (state_d == SETTLE && stab_d == STAB_DONE) begin
                    load        = 1'b1;
                    classify_en = 1'b1;
                    state_d     = TRACK;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase

        if (load) begin
            count_d       = cand_d;
            count_valid_d = 1'b1;
            if (classify_en) begin
                cls         = classify_step(32'(count_q), 32'(cand_d), WIDTH);
                wrap_up_d   = cls.wrap_up;
                wrap_down_d = cls.wrap_down;
                step_err_d  = cls.step_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= INIT;
            cand_q        <= '0;
            stab_q        <= '0;
            count_q       <= '0;
            count_valid_q <= 1'b0;
            wrap_up_q     <= 1'b0;
            wrap_down_q   <= 1'b0;
            step_err_q    <= 1'b0;
            prime_q       <= '0;
        end else begin
            state_q       <= state_d;
            cand_q        <= cand_d;
            stab_q        <= stab_d;
            count_q       <= count_d;
            count_valid_q <= count_valid_d;
            wrap_up_q     <= wrap_up_d;
            wrap_down_q   <= wrap_down_d;
            step_err_q    <= step_err_d;
            prime_q       <= prime_d;
        end
    end

    assign count       = count_q;
    assign count_valid = count_valid_q;
    assign wrap_up     = wrap_up_q;
    assign wrap_down   = wrap_down_q;
    assign step_err    = step_err_q;

endmodule

// File: tb/tb_ripple_count_sampler.sv
// tb/tb_ripple_count_sampler.sv - scoreboard bench for ripple_count_sampler
module tb_ripple_count_sampler;

    localparam int W  = 4;
    localparam int SS = 2;
    localparam int SC = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] cnt_async = '0;
    logic         up_down_async = 1'b0;
    logic [W-1:0] count;
    logic         count_valid, wrap_up, wrap_down, step_err, dir;

    ripple_count_sampler #(.WIDTH(W), .SYNC_STAGES(SS), .STABLE_CYCLES(SC)) dut (
        .clk           (clk),
        .rst           (rst),
        .cnt_async     (cnt_async),
        .up_down_async (up_down_async),
        .count         (count),
        .count_valid   (count_valid),
        .wrap_up       (wrap_up),
        .wrap_down     (wrap_down),
        .step_err      (step_err),
        .dir           (dir)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [W-1:0] cnt;
        logic         wu;
        logic         wd;
        logic         se;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a value is accepted once it has been observed SC times in a row
    // (after the synchroniser delay) and differs from the published count.
    logic [W-1:0] m_pipe [SS];
    logic         m_dpipe [SS];
    int           m_edges;
    int           m_run;
    logic [W-1:0] m_run_val;
    bit           m_loaded;
    logic [W-1:0] m_count;
    logic         m_dir;
    logic [W-1:0] m_s;
    logic [W-1:0] m_delta;
    exp_t         m_e;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SS; i++) begin
                m_pipe[i]  = '0;
                m_dpipe[i] = 1'b0;
            end
            m_edges   = 0;
            m_run     = 0;
            m_run_val = '0;
            m_loaded  = 0;
            m_count   = '0;
            m_dir     = 1'b0;
            exp_q.delete();
        end else begin
            m_s = m_pipe[SS-1];
            if (m_edges >= SS) begin
                if (m_run > 0 && m_s == m_run_val) m_run++;
                else begin
                    m_run_val = m_s;
                    m_run     = 1;
                end
                if (m_run == SC && (!m_loaded || m_s != m_count)) begin
                    m_e = '0;
                    m_e.cnt = m_s;
                    if (m_loaded) begin
                        m_delta = m_s - m_count;
                        if (m_delta == 1)                 m_e.wu = (m_count == {W{1'b1}});
                        else if (m_delta == {W{1'b1}})    m_e.wd = (m_count == '0);
                        else                              m_e.se = 1'b1;
                    end
                    exp_q.push_back(m_e);
                    m_count  = m_s;
                    m_loaded = 1;
                end
            end
            for (int i = SS - 1; i > 0; i--) begin
                m_pipe[i]  = m_pipe[i-1];
                m_dpipe[i] = m_dpipe[i-1];
            end
            m_pipe[0]  = cnt_async;
            m_dpipe[0] = up_down_async;
            m_dir      = m_dpipe[SS-1];
            if (m_edges < 1000) m_edges++;
        end
    end

    int   n_valid = 0, n_wu = 0, n_wd = 0, n_se = 0;
    exp_t mon_e;

    always @(negedge clk) begin
        if (rst) begin
            check("count_track", count, m_count);
            check("dir_track", dir, m_dir);
            if (count_valid) begin
                n_valid++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got count %0h expected no load", count);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("load_count", count, mon_e.cnt);
                    check("wrap_up", wrap_up, mon_e.wu);
                    check("wrap_down", wrap_down, mon_e.wd);
                    check("step_err", step_err, mon_e.se);
                end
            end else if (wrap_up || wrap_down || step_err) begin
                n_checks++;
                n_fail++;
                $display("FAIL stray_strobe: got %b%b%b expected 000", wrap_up, wrap_down, step_err);
            end
            if (wrap_up)   n_wu++;
            if (wrap_down) n_wd++;
            if (step_err)  n_se++;
        end
    end

    task automatic drive(input logic [W-1:0] v, input int n);
        cnt_async = v;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int v0, w0, s0;
        repeat (3) @(negedge clk);
        check("rst_count", count, 0);
        check("rst_valid", count_valid, 0);
        check("rst_dir", dir, 0);
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1 check("init_not_before_5th", count_valid, 0);
        @(posedge clk);
        #1 check("init_at_5th", count_valid, 1);
        check("init_count", count, 0);
        @(negedge clk);
        repeat (10) @(negedge clk);

        up_down_async = 1'b1;
        v0 = n_valid; w0 = n_wu; s0 = n_se;
        for (int i = 1; i <= 16; i++) drive(W'(i), 12);
        check("up_valids", n_valid - v0, 16);
        check("up_wraps", n_wu - w0, 1);
        check("up_step_errs", n_se - s0, 0);
        check("up_dir", dir, 1);

        up_down_async = 1'b0;
        drive(3, 12);
        v0 = n_valid; w0 = n_wd;
        drive(2, 12); drive(1, 12); drive(0, 12); drive(15, 12);
        check("down_valids", n_valid - v0, 4);
        check("down_wraps", n_wd - w0, 1);
        check("down_count", count, 15);

        drive(7, 12);
        v0 = n_valid; s0 = n_se;
        drive(6, 1); drive(4, 1); drive(8, 12);
        check("transient_valids", n_valid - v0, 1);
        check("transient_step_err", n_se - s0, 0);
        check("transient_count", count, 8);
        drive(7, 12);
        v0 = n_valid;
        drive(5, 2); drive(7, 12);
        check("glitch_valids", n_valid - v0, 0);

        drive(2, 12);
        s0 = n_se;
        drive(9, 12);
        check("jump_step_err", n_se - s0, 1);
        check("jump_count", count, 9);

        cnt_async = 5;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("midrst_count", count, 0);
        check("midrst_valid", count_valid, 0);
        check("midrst_strobes", {wrap_up, wrap_down, step_err}, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1 check("reinit_early", count_valid, 0);
        @(posedge clk);
        #1 check("reinit_valid", count_valid, 1);
        check("reinit_count", count, 5);
        check("reinit_step_err", step_err, 0);
        @(negedge clk);
        repeat (4) @(negedge clk);

        repeat (250) begin
            up_down_async = 1'($urandom);
            drive(W'($urandom), $urandom_range(1, 14));
        end
        drive(cnt_async, 20);

        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

endmodule
